// File: rtl/frame_writer.sv
// Consumer end of the show-ahead pixel stream: tracks raster position and writes
// each accepted pixel into a double-banked frame buffer with one cycle of latency.
module frame_writer #(
   parameter int IMG_W      = 225,
   parameter int IMG_H      = 225,
   parameter int PIX_W      = 8,
   parameter int ADDR_W     = 16,
   parameter int DOUBLE_BUF = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_stop,
   output logic              o_next,
   input  logic [PIX_W-1:0]  i_data,
   input  logic              i_valid,
   input  logic              i_wr_ready,
   output logic              o_wr_en,
   output logic [ADDR_W:0]   o_wr_addr,
   output logic [PIX_W-1:0]  o_wr_data,
   output logic [7:0]        o_x,
   output logic [7:0]        o_y,
   output logic              o_bank,
   output logic              o_frame_done,
   output logic              o_busy,
   output logic [15:0]       o_frame_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [7:0] X_LAST    = 8'(IMG_W - 1);
   localparam logic [7:0] Y_LAST    = 8'(IMG_H - 1);
   localparam logic       DB_TOGGLE = (DOUBLE_BUF != 0);

   state_t            state, state_nxt;
   logic [7:0]        x, y;
   logic [ADDR_W-1:0] pix_idx;
   logic              bank;
   logic              stop_req;
   logic              accept;
   logic              last_pix;

   assign o_next   = (state == RUN) && i_wr_ready;
   assign accept   = o_next && i_valid;
   assign last_pix = (x == X_LAST) && (y == Y_LAST);
   assign o_busy   = (state != IDLE);
   assign o_bank   = bank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = RUN;
         RUN:     if (accept && last_pix) state_nxt = DONE;
         DONE:    state_nxt = stop_req ? IDLE : RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x            <= '0;
         y            <= '0;
         pix_idx      <= '0;
         bank         <= 1'b0;
         stop_req     <= 1'b0;
         o_wr_en      <= 1'b0;
         o_wr_addr    <= '0;
         o_wr_data    <= '0;
         o_x          <= '0;
         o_y          <= '0;
         o_frame_done <= 1'b0;
         o_frame_cnt  <= '0;
      end else begin
         o_wr_en      <= accept;
         o_frame_done <= 1'b0;
         if (accept) begin
            o_wr_data <= i_data;
            o_wr_addr <= {bank, pix_idx};
            o_x       <= x;
            o_y       <= y;
            if (last_pix) begin
               x       <= '0;
               y       <= '0;
               pix_idx <= '0;
            end else if (x == X_LAST) begin
               x       <= '0;
               y       <= y + 8'd1;
               pix_idx <= pix_idx + ADDR_W'(1);
            end else begin
               x       <= x + 8'd1;
               pix_idx <= pix_idx + ADDR_W'(1);
            end
         end
         // Stop is only latched here; it is acted on at the frame boundary.
         if (state == RUN && i_stop) stop_req <= 1'b1;
         if (state == DONE) begin
            bank         <= bank ^ DB_TOGGLE;
            o_frame_cnt  <= o_frame_cnt + 16'd1;
            o_frame_done <= 1'b1;
            stop_req     <= 1'b0;
         end
      end
   end

endmodule
